if_fetch_unit: RTL and testbench

Instruction-fetch front end that drives the IF_Stage pipeline register.
- Holds the program counter and runs a req/ready handshake to instruction memory, which may insert wait states.
- Delivers {PC+4, Instruction} with a valid flag. Honours freeze from the hazard unit and redirects on taken branches from EXE.
- Discards any fetch that a branch overtakes while it is in flight.

---
 rtl/if_fetch_unit_pkg.sv | 8 +
 rtl/if_fetch_unit_if.sv | 14 +
 rtl/if_fetch_unit_pc_register.sv | 15 +
 rtl/if_fetch_unit.sv | 57 +++++
 tb/tb_if_fetch_unit.sv | 97 +++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, reset PC and fetch FSM state encodings.
package if_fetch_unit_pkg;
    localparam int ADDRESS_LEN = 32;
    localparam logic [ADDRESS_LEN-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [1:0] FS_FETCH = 2'd0;
    localparam logic [1:0] FS_HOLD  = 2'd1;
    localparam logic [1:0] FS_DRAIN = 2'd2;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: req/ready instruction-memory bus between fetch unit and memory.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDRESS_LEN,
    parameter int INSTR_W = ADDRESS_LEN
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ready;
    modport master (output mem_req, mem_addr, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/if_fetch_unit_pc_register.sv
// pc_register: program counter with async active-low reset and load enable.
module pc_register #(
    parameter int              W        = 32,
    parameter logic [W-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= RESET_PC;
        else if (en) q <= d;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC + req/ready fetch FSM feeding the IF stage register,
// with freeze holding and branch redirect that drains an overtaken fetch.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                  ADDR_W   = ADDRESS_LEN,
    parameter int                  INSTR_W  = ADDRESS_LEN,
    parameter logic [ADDR_W-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_address,
    if_fetch_unit_if.master     mem,
    output logic [ADDR_W-1:0]   PC,
    output logic [INSTR_W-1:0]  Instruction,
    output logic                instr_valid
);
    logic [1:0]         state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_d, drain_addr;
    logic [INSTR_W-1:0] hold_buf;
    logic               pc_en, fetch, hold, drain;

    pc_register #(.W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc)
    );

    always_comb begin
        fetch    = state == FS_FETCH;
        hold     = state == FS_HOLD;
        drain    = state == FS_DRAIN;
        pc_en    = branch_taken | (fetch & mem.mem_ready & ~freeze) | (hold & ~freeze);
        pc_d     = branch_taken ? branch_address : pc + ADDR_W'(4);
        // a drain always ends at FETCH: pc already holds the newest target
        state_nx = fetch ? (branch_taken ? (mem.mem_ready ? FS_FETCH : FS_DRAIN)
                                         : (mem.mem_ready & freeze ? FS_HOLD : FS_FETCH))
                 : hold  ? (branch_taken | ~freeze ? FS_FETCH : FS_HOLD)
                 :         (mem.mem_ready ? FS_FETCH : FS_DRAIN);
        mem.mem_req  = rst & ~hold;
        mem.mem_addr = drain ? drain_addr : pc;
        instr_valid  = rst & ~branch_taken & (hold | (fetch & mem.mem_ready));
        Instruction  = !rst ? '0 : hold ? hold_buf : fetch ? mem.mem_rdata : '0;
        PC           = pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= FS_FETCH;
            hold_buf   <= '0;
            drain_addr <= '0;
        end else begin
            state <= state_nx;
            if (fetch & mem.mem_ready & freeze & ~branch_taken) hold_buf <= mem.mem_rdata;
            if (fetch & ~mem.mem_ready & branch_taken) drain_addr <= pc;
        end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, wait states, freeze, branch drain, reset and wrap.
module tb_if_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5A5A5;
    logic        clk = 0, rst = 0, freeze = 0, branch_taken = 0;
    logic [31:0] branch_address = '0, PC, Instruction;
    logic        instr_valid;
    int          waits = 0, cnt = 0, vectors = 0, miscompares = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .mem(bus), .PC(PC),
        .Instruction(Instruction), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = bus.mem_req && (cnt >= waits);
    assign bus.mem_rdata = bus.mem_addr ^ K;
    always @(posedge clk) cnt <= (!bus.mem_req || bus.mem_ready) ? 0 : cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic deliver(input string tag, input logic [31:0] pc_exp, input logic [31:0] ins_exp);
        chk({tag, "_valid"}, 32'(instr_valid), 1);
        chk({tag, "_pc"}, PC, pc_exp);
        chk({tag, "_ins"}, Instruction, ins_exp);
    endtask

    task automatic bubble(input string tag, input logic [31:0] addr_exp);
        chk({tag, "_valid"}, 32'(instr_valid), 0);
        chk({tag, "_req"}, 32'(bus.mem_req), 1);
        chk({tag, "_addr"}, bus.mem_addr, addr_exp);
    endtask

    initial begin
        #1;
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ins", Instruction, 0);
        chk("rst_pc", PC, 32'h4);
        cyc; rst = 1; #1;
        chk("t1_addr0", bus.mem_addr, 32'h0);
        deliver("t1_c0", 32'h4, 32'hA5A5A5A5);
        cyc; #1; deliver("t1_c1", 32'h8, 32'hA5A5A5A1);
        cyc; #1; deliver("t1_c2", 32'hC, 32'hA5A5A5AD);
        cyc; #1; deliver("t1_c3", 32'h10, 32'hA5A5A5A9);
        cyc; freeze = 1; #1; deliver("t3_del", 32'h14, 32'hA5A5A5B5);
        cyc; #1; deliver("t3_h1", 32'h14, 32'hA5A5A5B5); chk("t3_h1_req", 32'(bus.mem_req), 0);
        cyc; #1; deliver("t3_h2", 32'h14, 32'hA5A5A5B5); chk("t3_h2_req", 32'(bus.mem_req), 0);
        cyc; freeze = 0; #1; deliver("t3_h3", 32'h14, 32'hA5A5A5B5); chk("t3_h3_req", 32'(bus.mem_req), 0);
        cyc; waits = 2; #1; bubble("t2_w0", 32'h14);
        cyc; #1; bubble("t2_w1", 32'h14);
        cyc; #1; deliver("t2_d0", 32'h18, 32'hA5A5A5B1); chk("t2_d0_addr", bus.mem_addr, 32'h14);
        cyc; #1; bubble("t2_w2", 32'h18);
        cyc; #1; bubble("t2_w3", 32'h18);
        cyc; #1; deliver("t2_d1", 32'h1C, 32'hA5A5A5BD);
        cyc; #1; bubble("t2_w4", 32'h1C);
        cyc; #1; bubble("t2_w5", 32'h1C);
        cyc; #1; deliver("t2_d2", 32'h20, 32'hA5A5A5B9);
        cyc; branch_taken = 1; branch_address = 32'h100; #1; bubble("t4_br", 32'h20);
        cyc; branch_taken = 0; #1; bubble("t4_dr1", 32'h20);
        cyc; #1; bubble("t4_dr2", 32'h20); chk("t4_dr2_ready", 32'(bus.mem_ready), 1);
        cyc; waits = 0; #1; deliver("t4_tgt", 32'h104, 32'hA5A5A4A5); chk("t4_tgt_addr", bus.mem_addr, 32'h100);
        cyc; freeze = 1; #1; deliver("t5_del", 32'h108, 32'hA5A5A4A1);
        cyc; branch_taken = 1; branch_address = 32'h200; #1;
        chk("t5_valid", 32'(instr_valid), 0); chk("t5_req", 32'(bus.mem_req), 0);
        cyc; branch_taken = 0; freeze = 0; #1;
        deliver("t5_tgt", 32'h204, 32'hA5A5A7A5); chk("t5_tgt_addr", bus.mem_addr, 32'h200);
        cyc; waits = 2; #1; bubble("t6_pend", 32'h204);
        rst = 0; #1;
        chk("t6_req", 32'(bus.mem_req), 0);
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_ins", Instruction, 0);
        chk("t6_pc", PC, 32'h4);
        cyc; rst = 1; waits = 0; branch_taken = 1; branch_address = 32'hFFFFFFFC; #1;
        chk("t6_br_valid", 32'(instr_valid), 0);
        cyc; branch_taken = 0; #1;
        deliver("t6_top", 32'h0, 32'h5A5A5A59); chk("t6_top_addr", bus.mem_addr, 32'hFFFFFFFC);
        cyc; #1;
        deliver("t6_wrap", 32'h4, 32'hA5A5A5A5); chk("t6_wrap_addr", bus.mem_addr, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
